// File: rtl/dl_ram_arbiter.sv
// Shares the single-port program RAM between the HPS ioctl download stream and the CPU,
// and holds the system in reset while a BIOS image is loaded and for a settle period after.
module dl_ram_arbiter #(
    parameter int AW             = 14,
    parameter int ROM_SIZE       = 16384,
    parameter int INDEX_MAX      = 2,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dn_download,
    input  logic [7:0]    dn_index,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [7:0]    dn_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    cpu_dout,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic          sys_hold,
    output logic          dl_busy,
    output logic [AW:0]   dl_count,
    output logic          dl_overflow
);

    localparam int              CW          = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(RELEASE_CYCLES);
    localparam bit              ROM_FULL    = (ROM_SIZE >= (1 << AW));
    localparam logic [AW:0]     ROM_LIMIT   = (AW + 1)'(ROM_SIZE);
    localparam logic [8:0]      INDEX_LIMIT = 9'(INDEX_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE
    } state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic          pend_valid;
    logic          grant_q;
    logic          dl_q;
    logic          dn_take;
    logic          dn_in_range;
    logic          cpu_grant;
    logic          load_entry;

    assign dl_q        = dn_download && ({1'b0, dn_index} < INDEX_LIMIT);
    assign dn_take     = dn_wr && dl_q;
    assign dn_in_range = ROM_FULL || ({1'b0, dn_addr} < ROM_LIMIT);
    assign load_entry  = (state == ST_IDLE) && dl_q;

    // A held request is ignored through the grant and ack cycles so each request yields one access.
    assign cpu_grant = (state == ST_IDLE) && cpu_req && !dn_take && !grant_q && !cpu_ack;
    assign cpu_dout  = cpu_ack ? ram_dout : 8'h00;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
            sys_hold   <= 1'b1;
            dl_busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dl_q) begin
                        state    <= ST_LOAD;
                        sys_hold <= 1'b1;
                        dl_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!dl_q && !pend_valid) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        dl_busy    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (dl_q) begin
                        state   <= ST_LOAD;
                        dl_busy <= 1'b1;
                    end else if (settle_cnt <= CW'(1)) begin
                        state    <= ST_IDLE;
                        sys_hold <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                default: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= SETTLE_LOAD;
                    sys_hold   <= 1'b1;
                    dl_busy    <= 1'b0;
                end
            endcase
        end
    end

    // The RAM port registers double as the pending-write slot, so a download byte refills it every cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid  <= 1'b0;
            grant_q     <= 1'b0;
            cpu_ack     <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= 8'h00;
            ram_we      <= 1'b0;
            dl_count    <= '0;
            dl_overflow <= 1'b0;
        end else begin
            grant_q    <= cpu_grant;
            cpu_ack    <= grant_q;
            pend_valid <= dn_take && dn_in_range;

            if (dn_take && dn_in_range) begin
                ram_addr <= dn_addr;
                ram_din  <= dn_data;
                ram_we   <= 1'b1;
            end else if (cpu_grant) begin
                ram_addr <= cpu_addr;
                ram_din  <= cpu_din;
                ram_we   <= cpu_we;
            end else begin
                ram_we <= 1'b0;
            end

            if (load_entry) begin
                dl_count <= {{AW{1'b0}}, pend_valid};
            end else if (pend_valid && (dl_count != '1)) begin
                dl_count <= dl_count + (AW + 1)'(1);
            end

            if (dn_take && !dn_in_range) begin
                dl_overflow <= 1'b1;
            end else if (load_entry) begin
                dl_overflow <= 1'b0;
            end
        end
    end

endmodule
